lemming_dig_arbiter: RTL

LEMMING_DIG_ARBITER -- requirements
Module: lemming_dig_arbiter

---
 rtl/lemming_dig_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lemming_dig_arbiter.sv
// Round-robin arbiter lending one digging tool to four lemmings, with a
// per-grant dig limit, ground-loss abort, timeout lock-out and cooldown gap.
module lemming_dig_arbiter #(
  parameter int MAX_DIG  = 16,
  parameter int COOLDOWN = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] req,
  input  logic [3:0] ground,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       timeout,
  output logic       abort,
  output logic [7:0] dig_cnt
);

  // state | meaning
  // IDLE  | tool free, eligible requests evaluated every cycle
  // GRANT | owner gnt_id digging, dig_cnt counts granted cycles
  // COOL  | forced idle gap of COOLDOWN cycles after a grant ends
  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

  localparam logic [7:0] DIG_LAST  = 8'(MAX_DIG - 1);
  localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN - 1);

  state_t     state, state_n;
  logic [3:0] lock, lock_n;
  logic [3:0] cool_cnt, cool_n;
  logic [3:0] gnt_n;
  logic       gnt_valid_n;
  logic [1:0] gnt_id_n;
  logic [7:0] dig_cnt_n;
  logic       timeout_n, abort_n;

  logic [3:0] elig;
  logic [1:0] start, idx, win;
  logic       found;
  logic       grant_end;

  always_comb begin
    elig  = req & ground & ~lock;
    start = gnt_id + 2'd1;
    idx   = 2'd0;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    dig_cnt_n = dig_cnt;
    timeout_n = 1'b0;
    abort_n   = 1'b0;
    cool_n    = cool_cnt;
    lock_n    = lock & req;
    grant_end = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_n   = GRANT;
          gnt_n     = 4'b0001 << win;
          gnt_id_n  = win;
          dig_cnt_n = 8'd0;
        end
      end
      GRANT: begin
        // fall beats release beats timeout when several hold on one edge
        if (!ground[gnt_id]) begin
          grant_end = 1'b1;
          abort_n   = 1'b1;
        end else if (!req[gnt_id]) begin
          grant_end = 1'b1;
        end else if (dig_cnt == DIG_LAST) begin
          grant_end      = 1'b1;
          timeout_n      = 1'b1;
          lock_n[gnt_id] = 1'b1;
        end else begin
          dig_cnt_n = dig_cnt + 8'd1;
        end
        if (grant_end) begin
          gnt_n     = 4'b0000;
          dig_cnt_n = 8'd0;
          if (COOLDOWN > 0) begin
            state_n = COOL;
            cool_n  = COOL_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      COOL: begin
        if (cool_cnt == 4'd0) state_n = IDLE;
        else                  cool_n  = cool_cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase

    gnt_valid_n = |gnt_n;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      gnt_id    <= 2'd3;
      timeout   <= 1'b0;
      abort     <= 1'b0;
      dig_cnt   <= 8'd0;
      lock      <= 4'b0000;
      cool_cnt  <= 4'd0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      gnt_id    <= gnt_id_n;
      timeout   <= timeout_n;
      abort     <= abort_n;
      dig_cnt   <= dig_cnt_n;
      lock      <= lock_n;
      cool_cnt  <= cool_n;
    end
  end

endmodule
